gate_vector_checker: RTL and testbench
======================================

Name: gate_vector_checker

Overview:
- Synthesizable stimulus/response checker for the four-output gate cell (c=a|b, d=a&b, e=~a, f=e^c).
- Drives a and b through all four input vectors, samples c/d/e/f, compares them with the expected truth table, and reports pass/fail.
- Sits on the opposite side of the gate cell, replacing the simulation-only stimulus/monitor bench with hardware that also runs on board.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after a vector is applied before sampling; legal range ≥1.
- ERR_W, 4, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle run request.
- a_o  output  1  stimulus a to the gate cell.
- b_o  output  1  stimulus b to the gate cell.
- c_i  input  1  gate-cell OR output.
- d_i  input  1  gate-cell AND output.
- e_i  input  1  gate-cell NOT output.
- f_i  input  1  gate-cell XOR output.
- busy  output  1  run in progress.
- done  output  1  run finished; held high until the next accepted start.
- pass  output  1  done with zero mismatches.
- err_cnt  output  ERR_W  count of mismatching vectors, saturating.
- first_fail_vec  output  2  {a,b} of the first mismatching vector.
- first_fail_mask  output  4  {f,e,d,c} XOR mask (actual vs expected) at the first mismatch.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM enters IDLE, applied asynchronously.
  - Reset mid-run aborts immediately; no partial results are retained.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Start acceptance:
  - start is sampled only in IDLE or DONE.
  - On the accepting edge (edge 0):
    - vec←0; {a_o,b_o}←00; busy←1; done←0; pass←0.
    - err_cnt, first_fail_vec and first_fail_mask are cleared.
    - settle counter←0; FSM→SETTLE.
  - start while busy is ignored.
- SETTLE: counts SETTLE_CYCLES edges, then moves to SAMPLE.
- SAMPLE (one cycle): on its edge, c_i..f_i are compared with the expected values for vec.
- Expected truth table ({a,b} → c d e f):
  - 00 → 0 0 1 1
  - 01 → 1 0 1 0
  - 10 → 1 0 0 1
  - 11 → 1 1 0 1
- On mismatch (any mask bit set):
  - err_cnt increments, saturating at 2^ERR_W−1.
  - On the first mismatch of the run, first_fail_vec and first_fail_mask are captured. Later mismatches do not overwrite them.
- Vector advance:
  - vec<3: vec++, {a_o,b_o}←vec+1, FSM→SETTLE.
  - vec==3: FSM→DONE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - The last sample falls on edge 4·(SETTLE_CYCLES+1). At that same edge: done←1, busy←0, pass←(final err_cnt==0).
- DONE:
  - {a_o,b_o}←00.
  - done, pass, err_cnt and the capture fields hold until the next accepted start or reset.
- start and the last sample on the same edge: start is not yet accepted because the FSM is not in DONE. start is accepted no earlier than the following cycle.
- Inputs c_i..f_i are treated as synchronous to clk. No synchronizers are inside the block.

Optional Feature:
- FAIL_STOP_EN:
  - When defined, the first mismatch ends the run on that SAMPLE edge: FSM→DONE, done←1, busy←0, pass←0, err_cnt=1, and {a_o,b_o}←00.
  - When undefined, all four vectors are always run and every mismatch is counted.

Test Plan:
- Correct gate cell, SETTLE_CYCLES=2, start pulse at edge 0:
  - a_o/b_o step 00, 01, 10, 11, holding each for 3 cycles.
  - done=1 and pass=1 after edge 12; err_cnt=0; busy=0.
- f_i stuck at 0, feature off:
  - err_cnt=3 (vectors 00, 10, 11 fail); first_fail_vec=00; first_fail_mask=1000; pass=0; done after edge 12.
- Same fault with FAIL_STOP_EN:
  - done=1 after edge 3; err_cnt=1; first_fail_vec=00; first_fail_mask=1000; a_o=b_o=0.
- ERR_W=1, all four outputs inverted:
  - err_cnt saturates at 1; first_fail_mask=1111; pass=0.
- start re-pulsed at edge 5 of a run: ignored, and done still arrives after edge 12.
- rst asserted at edge 7: all outputs 0 immediately and FSM in IDLE. A new start then produces a full clean run with pass=1.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the four-output gate cell (c=a|b, d=a&b, e=~a, f=e^c).
// Optional macro FAIL_STOP_EN: end the run at the first mismatching vector.
module gate_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic             c_i,
    input  logic             d_i,
    input  logic             e_i,
    input  logic             f_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_fail_vec,
    output logic [3:0]       first_fail_mask
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ErrMax = '1;

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        vec_q, vec_d;
    logic [1:0]        ab_q, ab_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [1:0]        ffv_q, ffv_d;
    logic [3:0]        ffm_q, ffm_d;
    logic [3:0]        mask;
    logic              mismatch;

    // Expected {f,e,d,c} for input vector {a,b}.
    function automatic logic [3:0] exp_fedc(input logic [1:0] v);
        logic [3:0] r;
        unique case (v)
            2'b00:   r = 4'b1100;
            2'b01:   r = 4'b0101;
            2'b10:   r = 4'b1001;
            default: r = 4'b1011;
        endcase
        return r;
    endfunction

    assign mask     = {f_i, e_i, d_i, c_i} ^ exp_fedc(vec_q);
    assign mismatch = |mask;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ab_d    = ab_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSettle;
                    vec_d   = 2'b00;
                    ab_d    = 2'b00;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ffv_d   = 2'b00;
                    ffm_d   = 4'b0000;
                end
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin // StSample
                if (mismatch) begin
                    if (err_q != ErrMax) begin
                        err_d = err_q + 1'b1;
                    end
                    // A saturating counter never returns to zero, so zero means "first".
                    if (err_q == '0) begin
                        ffv_d = vec_q;
                        ffm_d = mask;
                    end
                end
`ifdef FAIL_STOP_EN
                if (mismatch || vec_q == 2'b11) begin
`else
                if (vec_q == 2'b11) begin
`endif
                    state_d = StDone;
                    ab_d    = 2'b00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = StSettle;
                    vec_d   = vec_q + 1'b1;
                    ab_d    = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= 2'b00;
            ab_q    <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 2'b00;
            ffm_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            ab_q    <= ab_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffm_q   <= ffm_d;
        end
    end

    assign a_o             = ab_q[1];
    assign b_o             = ab_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: a healthy / f-stuck-low gate cell on the default checker, and an
// all-outputs-inverted cell on a 1-bit error counter instance.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   fault_a = 0;  // 0: healthy cell, 1: f stuck low

    logic       a_a, b_a, c_a, d_a, e_a, f_a, busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [1:0] ffv_a;
    logic [3:0] ffm_a;

    logic       a_b, b_b, c_b, d_b, e_b, f_b, busy_b, done_b, pass_b;
    logic [0:0] err_b;
    logic [1:0] ffv_b;
    logic [3:0] ffm_b;

    int n_checks = 0;
    int n_fail   = 0;

    assign c_a = a_a | b_a;
    assign d_a = a_a & b_a;
    assign e_a = ~a_a;
    assign f_a = (fault_a == 1) ? 1'b0 : ((~a_a) ^ (a_a | b_a));

    assign c_b = ~(a_b | b_b);
    assign d_b = ~(a_b & b_b);
    assign e_b = a_b;
    assign f_b = ~((~a_b) ^ (a_b | b_b));

    always #5 clk = ~clk;

    gate_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .a_o(a_a), .b_o(b_a), .c_i(c_a), .d_i(d_a), .e_i(e_a), .f_i(f_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_fail_vec(ffv_a), .first_fail_mask(ffm_a)
    );

    gate_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .a_o(a_b), .b_o(b_b), .c_i(c_b), .d_i(d_b), .e_i(e_b), .f_i(f_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_fail_vec(ffv_b), .first_fail_mask(ffm_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero_a(input string tag);
        check_eq({tag, "_ab"},   {a_a, b_a}, 0);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_done"}, done_a, 0);
        check_eq({tag, "_pass"}, pass_a, 0);
        check_eq({tag, "_err"},  err_a, 0);
        check_eq({tag, "_ffv"},  ffv_a, 0);
        check_eq({tag, "_ffm"},  ffm_a, 0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero_a("rst");
        check_eq("rst_b_err", err_b, 0);
        check_eq("rst_b_done", done_b, 0);
        tick();
        rst = 1'b0;

        // Healthy run with a stray start at edge 5 and start held across edges 12 and 13
        fault_a = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("e0_busy", busy_a, 1);
        check_eq("e0_ab", {a_a, b_a}, 0);
        for (int e = 1; e <= 12; e++) begin
            start_a = (e == 5) || (e == 12);
            tick();
            if (e == 5) start_a = 1'b0;
            check_eq($sformatf("clean_ab_e%0d", e), {a_a, b_a}, (e < 12) ? e / 3 : 0);
            check_eq($sformatf("clean_busy_e%0d", e), busy_a, (e < 12) ? 1 : 0);
            check_eq($sformatf("clean_done_e%0d", e), done_a, (e == 12) ? 1 : 0);
        end
        check_eq("clean_pass", pass_a, 1);
        check_eq("clean_err", err_a, 0);
        tick();  // edge 13: start now seen in DONE
        start_a = 1'b0;
        check_eq("restart_busy", busy_a, 1);
        check_eq("restart_done", done_a, 0);
        check_eq("restart_pass", pass_a, 0);
        repeat (12) tick();
        check_eq("rerun_done", done_a, 1);
        check_eq("rerun_pass", pass_a, 1);

        // f stuck low
        fault_a = 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
`ifdef FAIL_STOP_EN
        repeat (3) tick();
        check_eq("fstop_done", done_a, 1);
        check_eq("fstop_busy", busy_a, 0);
        check_eq("fstop_err", err_a, 1);
        check_eq("fstop_ab", {a_a, b_a}, 0);
`else
        repeat (11) tick();
        check_eq("fstuck_done_e11", done_a, 0);
        tick();
        check_eq("fstuck_done", done_a, 1);
        check_eq("fstuck_err", err_a, 3);
`endif
        check_eq("fstuck_pass", pass_a, 0);
        check_eq("fstuck_ffv", ffv_a, 0);
        check_eq("fstuck_ffm", ffm_a, 4'b1000);

        // Asynchronous reset shortly after edge 7 of a faulty run
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
`ifndef FAIL_STOP_EN
        check_eq("pre_rst_ab", {a_a, b_a}, 2'b10);
        check_eq("pre_rst_err", err_a, 1);
`endif
        rst = 1'b1;
        #1;
        check_all_zero_a("midrst");
        tick();
        rst = 1'b0;
        tick();
        check_eq("idle_busy", busy_a, 0);
        fault_a = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (12) tick();
        check_eq("postrst_done", done_a, 1);
        check_eq("postrst_pass", pass_a, 1);
        check_eq("postrst_err", err_a, 0);

        // ERR_W=1, all outputs inverted
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
`ifdef FAIL_STOP_EN
        repeat (3) tick();
`else
        repeat (12) tick();
`endif
        check_eq("inv_done", done_b, 1);
        check_eq("inv_err", err_b, 1);
        check_eq("inv_ffm", ffm_b, 4'b1111);
        check_eq("inv_ffv", ffv_b, 0);
        check_eq("inv_pass", pass_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
